// File: rtl/disp_arbiter.sv
// disp_arbiter: round-robin ownership of a 4-digit segment display among three clients
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req[2:0]            level request per client
//   data0..data2[27:0]  client digits {d3,d2,d1,d0}, 7 bits each, active-low segments
//   grant[2:0]          one-hot current owner, zero in idle/blank
//   owner[1:0]          current or last owner, 3 until the first grant
//   disp3..disp0[6:0]   registered digit data to the scanner, 7'h7F when blank
module disp_arbiter #(
  parameter int HOLD_CYCLES  = 100_000_000,
  parameter int BLANK_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [27:0] data0,
  input  logic [27:0] data1,
  input  logic [27:0] data2,
  output logic [2:0]  grant,
  output logic [1:0]  owner,
  output logic [6:0]  disp3,
  output logic [6:0]  disp2,
  output logic [6:0]  disp1,
  output logic [6:0]  disp0
);
  typedef enum logic [1:0] {IDLE, OWN, BLANK} state_t;
  localparam logic [26:0] HOLD_MAX  = 27'(HOLD_CYCLES - 1);
  localparam logic [26:0] BLANK_MAX = 27'(BLANK_CYCLES - 1);
  state_t      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [1:0]  owner_q, owner_d;
  logic [26:0] hold_q, hold_d, blank_q, blank_d;
  logic [27:0] disp_q, disp_d, sel;
  logic [1:0]  base, c1, c2, win;
  logic        others;
  // treating "no owner yet" as owner 2 makes the search order 0,1,2 after reset
  assign base   = owner_q == 2'd3 ? 2'd2 : owner_q;
  assign c1     = base == 2'd2 ? 2'd0 : base + 2'd1;
  assign c2     = c1 == 2'd2 ? 2'd0 : c1 + 2'd1;
  assign win    = req[c1] ? c1 : req[c2] ? c2 : base;
  assign others = |(req & ~(3'b001 << owner_q));
  assign sel    = owner_q == 2'd0 ? data0 : owner_q == 2'd1 ? data1 : data2;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    hold_d  = hold_q;
    blank_d = blank_q;
    disp_d  = state_q == OWN ? sel : 28'hFFFFFFF;
    case (state_q)
      IDLE: if (|req) begin
        state_d = OWN;
        owner_d = win;
        grant_d = 3'b001 << win;
        hold_d  = '0;
      end
      OWN: if (!req[owner_q] || (hold_q == HOLD_MAX && others)) begin
        state_d = BLANK;
        grant_d = '0;
        blank_d = '0;
      end else hold_d = hold_q == HOLD_MAX ? hold_q : hold_q + 27'd1;
      default: if (blank_q == BLANK_MAX) begin
        state_d = |req ? OWN : IDLE;
        blank_d = '0;
        hold_d  = '0;
        if (|req) begin
          owner_d = win;
          grant_d = 3'b001 << win;
        end
      end else blank_d = blank_q + 27'd1;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= 2'd3;
      hold_q  <= '0;
      blank_q <= '0;
      disp_q  <= 28'hFFFFFFF;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      hold_q  <= hold_d;
      blank_q <= blank_d;
      disp_q  <= disp_d;
    end
  assign grant = grant_q;
  assign owner = owner_q;
  assign {disp3, disp2, disp1, disp0} = disp_q;
endmodule

// File: tb/tb_disp_arbiter.sv
// tb_disp_arbiter: directed self-checking bench for disp_arbiter with HOLD=8, BLANK=2
module tb_disp_arbiter;
  logic        clk = 0, rst = 1;
  logic [2:0]  req = '0, grant;
  logic [1:0]  owner;
  logic [27:0] data0 = 28'h0123456, data1 = 28'h0ABCDEF, data2 = 28'h5A5A5A5;
  logic [6:0]  disp3, disp2, disp1, disp0;
  int total = 0, bad = 0;
  localparam logic [27:0] BLK = 28'hFFFFFFF;
  disp_arbiter #(.HOLD_CYCLES(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1), .data2(data2),
    .grant(grant), .owner(owner), .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [27:0] disp_all();
    return {disp3, disp2, disp1, disp0};
  endfunction
  logic [2:0] exp_g;
  logic [2:0] seq [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  initial begin
    tick(2);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_owner", 32'(owner), 32'h3);
    chk("rst_disp", 32'(disp_all()), 32'(BLK));
    rst = 0;
    req = 3'b011;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_g = i <= 8 ? 3'b001 : i <= 10 ? 3'b000 : 3'b010;
      chk($sformatf("hold_grant%0d", i), 32'(grant), 32'(exp_g));
      if (i == 1) chk("first_own_blank", 32'(disp_all()), 32'(BLK));
      if (i == 2) chk("disp_data0", 32'(disp_all()), 32'(data0));
      if (i == 10) chk("gap_disp", 32'(disp_all()), 32'(BLK));
      if (i == 12) chk("disp_data1", 32'(disp_all()), 32'(data1));
    end
    tick(2);
    req = 3'b001;
    tick();
    chk("drop_blank", 32'(grant), 32'h0);
    chk("drop_owner_kept", 32'(owner), 32'h1);
    tick();
    chk("drop_blank2", 32'(grant), 32'h0);
    tick();
    chk("drop_regrant", 32'(grant), 32'b001);
    chk("drop_owner", 32'(owner), 32'h0);
    req = 3'b111;
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < (s == 3 ? 1 : 10); k++) begin
        chk($sformatf("rr_s%0d_k%0d", s, k), 32'(grant), 32'(k < 8 ? seq[s] : 3'b000));
        tick();
      end
    req = 3'b001;
    tick(20);
    chk("alone_grant", 32'(grant), 32'b001);
    chk("alone_disp", 32'(disp_all()), 32'(data0));
    data0 = 28'h7654321;
    tick();
    chk("live_data", 32'(disp_all()), 32'h7654321);
    req = 3'b000;
    tick(2);
    chk("idle_gap", 32'(grant), 32'h0);
    tick();
    chk("idle_grant", 32'(grant), 32'h0);
    chk("idle_owner", 32'(owner), 32'h0);
    chk("idle_disp", 32'(disp_all()), 32'(BLK));
    req = 3'b001;
    tick();
    chk("idle_req_grant", 32'(grant), 32'b001);
    chk("idle_req_disp", 32'(disp_all()), 32'(BLK));
    tick();
    chk("idle_req_data", 32'(disp_all()), 32'(data0));
    req = 3'b010;
    tick();
    chk("swap_no_handover", 32'(grant), 32'h0);
    tick(2);
    chk("swap_grant", 32'(grant), 32'b010);
    chk("swap_owner", 32'(owner), 32'h1);
    tick(3);
    #2 rst = 1;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_owner", 32'(owner), 32'h3);
    chk("async_disp", 32'(disp_all()), 32'(BLK));
    req = 3'b100;
    tick(2);
    rst = 0;
    tick();
    chk("post_rst_grant", 32'(grant), 32'b100);
    chk("post_rst_owner", 32'(owner), 32'h2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
